// File: rtl/xy_ni_tx.sv
// Transmit network interface: packs PE words into XY packets and feeds the switch RESOURCE FIFO.
// Optional build macro XY_NI_STATS_EN adds saturating tx/drop counters (tied to 0 otherwise).
module xy_ni_tx #(
    parameter int COL_CORD        = 0,
    parameter int ROW_CORD        = 0,
    parameter int MESH_COLS       = 4,
    parameter int MESH_ROWS       = 4,
    parameter int FIFO_DEPTH_W    = 2,
    parameter int PCKT_COL_ADDR_W = 4,
    parameter int PCKT_ROW_ADDR_W = 4,
    parameter int PCKT_DATA_W     = 8,
    parameter int PCKT_W          = PCKT_COL_ADDR_W + PCKT_ROW_ADDR_W + PCKT_DATA_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [PCKT_COL_ADDR_W-1:0] dst_col_i,
    input  logic [PCKT_ROW_ADDR_W-1:0] dst_row_i,
    input  logic [PCKT_DATA_W-1:0]     data_i,
    output logic                       wr_en_o,
    output logic [PCKT_W-1:0]          pckt_o,
    input  logic                       nxt_fifo_full_i,
    input  logic                       nxt_fifo_overflow_i,
    output logic                       addr_err_o,
    output logic                       ovf_err_o,
    output logic [15:0]                tx_cnt_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_W;
    localparam logic [FIFO_DEPTH_W:0] PTR_ONE = {{FIFO_DEPTH_W{1'b0}}, 1'b1};

    // The attached switch must itself lie inside the mesh.
    if (COL_CORD >= MESH_COLS || ROW_CORD >= MESH_ROWS) begin : g_coord_chk
        $error("xy_ni_tx: switch coordinate outside mesh");
    end

    logic [PCKT_W-1:0]       fifo_mem [DEPTH];
    logic [FIFO_DEPTH_W:0]   wr_ptr;
    logic [FIFO_DEPTH_W:0]   rd_ptr;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    accept;
    logic                    addr_ok;
    logic                    push;
    logic                    drop;
    logic                    pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_DEPTH_W] != rd_ptr[FIFO_DEPTH_W]) &&
                        (wr_ptr[FIFO_DEPTH_W-1:0] == rd_ptr[FIFO_DEPTH_W-1:0]);

    assign ready_o = !fifo_full;
    assign accept  = valid_i && ready_o;
    assign addr_ok = (32'(dst_col_i) < MESH_COLS) && (32'(dst_row_i) < MESH_ROWS);
    assign push    = accept && addr_ok;
    assign drop    = accept && !addr_ok;

    // Emptiness follows the pointers, which clear asynchronously, so wr_en_o drops with reset.
    assign wr_en_o = !fifo_empty && !nxt_fifo_full_i;
    assign pop     = wr_en_o;
    assign pckt_o  = fifo_empty ? '0 : fifo_mem[rd_ptr[FIFO_DEPTH_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_DEPTH_W-1:0]] <= {dst_col_i, dst_row_i, data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            addr_err_o <= 1'b0;
            ovf_err_o  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop) begin
                addr_err_o <= 1'b1;
            end
            if (nxt_fifo_overflow_i) begin
                ovf_err_o <= 1'b1;
            end
        end
    end

`ifdef XY_NI_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] tx_cnt;
    logic [15:0] drop_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (pop) begin
                tx_cnt <= sat_inc(tx_cnt);
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    assign tx_cnt_o   = tx_cnt;
    assign drop_cnt_o = drop_cnt;
`else
    assign tx_cnt_o   = 16'd0;
    assign drop_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_xy_ni_tx.sv
// Directed bench for xy_ni_tx with default parameters (4x4 mesh, 4-entry FIFO).
module tb_xy_ni_tx;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  dst_col_i;
    logic [3:0]  dst_row_i;
    logic [7:0]  data_i;
    logic        wr_en_o;
    logic [15:0] pckt_o;
    logic        nxt_fifo_full_i;
    logic        nxt_fifo_overflow_i;
    logic        addr_err_o;
    logic        ovf_err_o;
    logic [15:0] tx_cnt_o;
    logic [15:0] drop_cnt_o;

    int vectors = 0;
    int miscompares = 0;

`ifdef XY_NI_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    xy_ni_tx dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .valid_i            (valid_i),
        .ready_o            (ready_o),
        .dst_col_i          (dst_col_i),
        .dst_row_i          (dst_row_i),
        .data_i             (data_i),
        .wr_en_o            (wr_en_o),
        .pckt_o             (pckt_o),
        .nxt_fifo_full_i    (nxt_fifo_full_i),
        .nxt_fifo_overflow_i(nxt_fifo_overflow_i),
        .addr_err_o         (addr_err_o),
        .ovf_err_o          (ovf_err_o),
        .tx_cnt_o           (tx_cnt_o),
        .drop_cnt_o         (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are read 2 time units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [3:0] col, input logic [3:0] row,
                         input logic [7:0] d);
        valid_i   = v;
        dst_col_i = col;
        dst_row_i = row;
        data_i    = d;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        valid_i = 1'b0;
        dst_col_i = '0;
        dst_row_i = '0;
        data_i = '0;
        nxt_fifo_full_i = 1'b0;
        nxt_fifo_overflow_i = 1'b0;
        #1;

        // Reset state
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_wr_en", 32'(wr_en_o), 32'd0);
        chk("rst_pckt", 32'(pckt_o), 32'h0);
        chk("rst_addr_err", 32'(addr_err_o), 32'd0);
        chk("rst_ovf_err", 32'(ovf_err_o), 32'd0);
        chk("rst_tx_cnt", 32'(tx_cnt_o), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Single word (2,1,A5)
        drive(1'b1, 4'd2, 4'd1, 8'hA5);
        chk("single_pre_wr_en", 32'(wr_en_o), 32'd0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 8'h00);
        chk("single_wr_en", 32'(wr_en_o), 32'd1);
        chk("single_pckt", 32'(pckt_o), 32'h21A5);
        tick();
        chk("single_wr_en_off", 32'(wr_en_o), 32'd0);
        chk("single_pckt_off", 32'(pckt_o), 32'h0);
        chk("single_tx_cnt", 32'(tx_cnt_o), STATS ? 32'd1 : 32'd0);

        // Fill under back-pressure; (0,0) is the self-address
        nxt_fifo_full_i = 1'b1;
        drive(1'b1, 4'd0, 4'd0, 8'h01);
        tick();
        chk("fill1_ready", 32'(ready_o), 32'd1);
        chk("fill1_wr_en", 32'(wr_en_o), 32'd0);
        drive(1'b1, 4'd1, 4'd1, 8'h02);
        tick();
        drive(1'b1, 4'd3, 4'd3, 8'h03);
        tick();
        chk("fill3_ready", 32'(ready_o), 32'd1);
        drive(1'b1, 4'd2, 4'd0, 8'h04);
        tick();
        chk("fill4_ready", 32'(ready_o), 32'd0);
        chk("fill4_wr_en", 32'(wr_en_o), 32'd0);
        drive(1'b1, 4'd1, 4'd0, 8'hEE);
        tick();
        chk("full_hold_ready", 32'(ready_o), 32'd0);
        drive(1'b0, 4'd0, 4'd0, 8'h00);
        nxt_fifo_full_i = 1'b0;
        #1;
        chk("drain1_wr_en", 32'(wr_en_o), 32'd1);
        chk("drain1_pckt", 32'(pckt_o), 32'h0001);
        tick();
        chk("drain2_wr_en", 32'(wr_en_o), 32'd1);
        chk("drain2_pckt", 32'(pckt_o), 32'h1102);
        chk("drain2_ready", 32'(ready_o), 32'd1);
        tick();
        chk("drain3_wr_en", 32'(wr_en_o), 32'd1);
        chk("drain3_pckt", 32'(pckt_o), 32'h3303);
        tick();
        chk("drain4_wr_en", 32'(wr_en_o), 32'd1);
        chk("drain4_pckt", 32'(pckt_o), 32'h2004);
        tick();
        chk("drain_done_wr_en", 32'(wr_en_o), 32'd0);
        chk("drain_done_pckt", 32'(pckt_o), 32'h0);
        chk("drain_tx_cnt", 32'(tx_cnt_o), STATS ? 32'd5 : 32'd0);

        // Streaming: one packet per cycle with simultaneous push and pop
        drive(1'b1, 4'd1, 4'd2, 8'h10);
        tick();
        chk("stream1_wr_en", 32'(wr_en_o), 32'd1);
        chk("stream1_pckt", 32'(pckt_o), 32'h1210);
        chk("stream1_ready", 32'(ready_o), 32'd1);
        drive(1'b1, 4'd1, 4'd2, 8'h11);
        tick();
        chk("stream2_wr_en", 32'(wr_en_o), 32'd1);
        chk("stream2_pckt", 32'(pckt_o), 32'h1211);
        chk("stream2_ready", 32'(ready_o), 32'd1);
        drive(1'b1, 4'd3, 4'd0, 8'h12);
        tick();
        chk("stream3_pckt", 32'(pckt_o), 32'h3012);
        chk("stream3_ready", 32'(ready_o), 32'd1);
        drive(1'b0, 4'd0, 4'd0, 8'h00);
        tick();
        chk("stream_done_wr_en", 32'(wr_en_o), 32'd0);
        chk("stream_tx_cnt", 32'(tx_cnt_o), STATS ? 32'd8 : 32'd0);

        // Out-of-range destinations are consumed and dropped
        chk("pre_drop_addr_err", 32'(addr_err_o), 32'd0);
        drive(1'b1, 4'd5, 4'd0, 8'h55);
        chk("bad_col_ready", 32'(ready_o), 32'd1);
        tick();
        drive(1'b0, 4'd0, 4'd0, 8'h00);
        chk("bad_col_wr_en", 32'(wr_en_o), 32'd0);
        chk("bad_col_addr_err", 32'(addr_err_o), 32'd1);
        chk("bad_col_drop_cnt", 32'(drop_cnt_o), STATS ? 32'd1 : 32'd0);
        drive(1'b1, 4'd3, 4'd4, 8'h66);
        tick();
        drive(1'b0, 4'd0, 4'd0, 8'h00);
        chk("bad_row_wr_en", 32'(wr_en_o), 32'd0);
        chk("bad_row_drop_cnt", 32'(drop_cnt_o), STATS ? 32'd2 : 32'd0);
        tick();
        chk("addr_err_sticky", 32'(addr_err_o), 32'd1);
        chk("drop_tx_cnt", 32'(tx_cnt_o), STATS ? 32'd8 : 32'd0);

        // Overflow pulse is sticky
        chk("pre_ovf", 32'(ovf_err_o), 32'd0);
        nxt_fifo_overflow_i = 1'b1;
        tick();
        nxt_fifo_overflow_i = 1'b0;
        chk("ovf_set", 32'(ovf_err_o), 32'd1);
        tick();
        tick();
        chk("ovf_sticky", 32'(ovf_err_o), 32'd1);

        // Reset with three packets queued
        nxt_fifo_full_i = 1'b1;
        drive(1'b1, 4'd1, 4'd1, 8'hC1);
        tick();
        drive(1'b1, 4'd2, 4'd2, 8'hC2);
        tick();
        drive(1'b1, 4'd3, 4'd3, 8'hC3);
        tick();
        drive(1'b0, 4'd0, 4'd0, 8'h00);
        nxt_fifo_full_i = 1'b0;
        #1;
        chk("queued_wr_en", 32'(wr_en_o), 32'd1);
        chk("queued_pckt", 32'(pckt_o), 32'h11C1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en_o), 32'd0);
        chk("mid_rst_pckt", 32'(pckt_o), 32'h0);
        chk("mid_rst_addr_err", 32'(addr_err_o), 32'd0);
        chk("mid_rst_ovf_err", 32'(ovf_err_o), 32'd0);
        chk("mid_rst_tx_cnt", 32'(tx_cnt_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_wr_en", 32'(wr_en_o), 32'd0);
            chk("post_rst_pckt", 32'(pckt_o), 32'h0);
            chk("post_rst_ready", 32'(ready_o), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xy_ni_tx.md
Name: xy_ni_tx

Overview:
- Transmit-side network interface between a processing element (PE) and the RESOURCE input port of one xy_switch.
- Accepts destination-addressed words from the PE over a valid/ready handshake and assembles them into XY packets.
- Buffers the packets in a local FIFO and writes them into the switch input FIFO using the switch's wr_en / full / overflow signalling.
- Sits directly upstream of xy_switch port 0 (RESOURCE).

Parameters:
- COL_CORD, 0, column coordinate of the attached switch.
- ROW_CORD, 0, row coordinate of the attached switch.
- MESH_COLS, 4, number of mesh columns; valid destination column is 0..MESH_COLS-1.
- MESH_ROWS, 4, number of mesh rows; valid destination row is 0..MESH_ROWS-1.
- FIFO_DEPTH_W, 2, local FIFO depth = 2**FIFO_DEPTH_W entries.
- PCKT_COL_ADDR_W, 4, width of the column address field.
- PCKT_ROW_ADDR_W, 4, width of the row address field.
- PCKT_DATA_W, 8, width of the payload field.
- PCKT_W, PCKT_COL_ADDR_W+PCKT_ROW_ADDR_W+PCKT_DATA_W, total packet width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  PE word valid.
- ready_o  out  1  NI can accept a word.
- dst_col_i  in  PCKT_COL_ADDR_W  destination column.
- dst_row_i  in  PCKT_ROW_ADDR_W  destination row.
- data_i  in  PCKT_DATA_W  payload.
- wr_en_o  out  1  write strobe to switch input FIFO.
- pckt_o  out  PCKT_W  packet to switch.
- nxt_fifo_full_i  in  1  switch input FIFO full.
- nxt_fifo_overflow_i  in  1  switch input FIFO overflow.
- addr_err_o  out  1  sticky: an out-of-range destination was dropped.
- ovf_err_o  out  1  sticky: switch reported overflow.
- tx_cnt_o  out  16  packets sent (optional feature).
- drop_cnt_o  out  16  packets dropped (optional feature).

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: FIFO empty, ready_o=1, wr_en_o=0, pckt_o=0, addr_err_o=0, ovf_err_o=0, tx_cnt_o=0, drop_cnt_o=0.
- Packet format: pckt = {col[PCKT_W-1 -: COL_W], row[next ROW_W bits], data[PCKT_DATA_W-1:0]}.
- Acceptance: a word is accepted on a rising edge when valid_i && ready_o.
  - ready_o = !fifo_full. Acceptance does not depend on a same-cycle pop, so a full FIFO never pushes.
- Address check (at acceptance):
  - If dst_col_i >= MESH_COLS or dst_row_i >= MESH_ROWS, the word is consumed but not pushed.
  - addr_err_o sets and stays set until reset; drop_cnt increments.
- Self-addressed packets (dst == COL_CORD,ROW_CORD) are legal and pushed normally; the switch loops them back.
- Switch-side handshake:
  - wr_en_o = !fifo_empty && !nxt_fifo_full_i (combinational from full).
  - pckt_o = FIFO head while non-empty, else 0.
  - The FIFO pops on every cycle wr_en_o=1.
- Latency: a word accepted at edge k appears as wr_en_o=1 in cycle k+1 at the earliest. Throughput is 1 packet/cycle.
- Simultaneous push and pop: both occur; occupancy is unchanged.
- Wrap-around: read/write pointers are FIFO_DEPTH_W+1 bits; full when MSBs differ and the rest are equal.
- Ordering: packets leave in acceptance order; there is no reordering.
- nxt_fifo_overflow_i=1 on any edge sets ovf_err_o (sticky). The NI takes no other action.
- Reset mid-operation: FIFO contents are discarded immediately, and wr_en_o drops asynchronously with reset.

Optional Feature:
- XY_NI_STATS_EN defined:
  - tx_cnt_o increments on each wr_en_o cycle.
  - drop_cnt_o increments on each address-error drop.
  - Both are 16-bit and saturate at 16'hFFFF.
- Not defined: counter logic is absent; tx_cnt_o and drop_cnt_o are tied to 0. The port list is unchanged.

Test Plan:
- Reset then one word (dst 2,1, data 0xA5), nxt_fifo_full_i=0 -> next cycle wr_en_o=1, pckt_o=0x21A5, for exactly one cycle.
- Hold nxt_fifo_full_i=1 and push 4 words (FIFO_DEPTH_W=2) -> ready_o=0 after the 4th, wr_en_o=0 throughout. Release full -> 4 packets on 4 consecutive cycles, in order.
- Continuous valid_i with full=0 -> 1 packet/cycle, ready_o stays 1, FIFO never exceeds 1 entry.
- Word with dst_col=5 (MESH_COLS=4) -> no wr_en_o, addr_err_o=1 sticky, drop_cnt_o=1 with XY_NI_STATS_EN.
- Pulse nxt_fifo_overflow_i for one cycle -> ovf_err_o=1 until rst_ni low.
- Assert rst_ni low with 3 entries queued -> wr_en_o=0 immediately; after release, no stale packets are emitted.
